// File: rtl/sys_array_pkg.sv
// Shared definitions for the 4x4 fixed-point systolic array and its feeder.
package sys_array_pkg;

    localparam int N      = 4;
    localparam int DATA_W = 16;
    localparam int STEPS  = 2 * N - 1;

    // Q8.8 signed fixed-point operand
    typedef logic signed [DATA_W-1:0] q8_8_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/systolic_feeder_bank.sv
// Operand bank for the systolic feeder: matrices A (sel=0) and B (sel=1),
// 16 entries each, one write port and PORTS combinational read ports.
// FEEDER_PINGPONG_EN: writes land in a shadow copy that is transferred to the
// active copy on load; reads always come from the active copy.
module systolic_feeder_bank
    import sys_array_pkg::*;
#(
    parameter int PORTS = 2 * N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [3:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
`ifdef FEEDER_PINGPONG_EN
    input  logic              load,
`endif
    input  logic              rd_sel  [PORTS],
    input  logic [1:0]        rd_row  [PORTS],
    input  logic [1:0]        rd_col  [PORTS],
    output logic [DATA_W-1:0] rd_data [PORTS]
);

    q8_8_t active [2][16];

`ifdef FEEDER_PINGPONG_EN
    q8_8_t shadow [2][16];

    // Shadow takes every write; load copies shadow (with this cycle's write merged) into active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < 2; s++) begin
                for (int unsigned e = 0; e < 16; e++) begin
                    shadow[s][e] <= '0;
                    active[s][e] <= '0;
                end
            end
        end else begin
            if (wr_en) begin
                shadow[wr_sel][wr_addr] <= wr_data;
            end
            if (load) begin
                for (int unsigned s = 0; s < 2; s++) begin
                    for (int unsigned e = 0; e < 16; e++) begin
                        active[s][e] <= shadow[s][e];
                    end
                end
                if (wr_en) begin
                    active[wr_sel][wr_addr] <= wr_data;
                end
            end
        end
    end
`else
    // Single bank: accepted writes update the element on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < 2; s++) begin
                for (int unsigned e = 0; e < 16; e++) begin
                    active[s][e] <= '0;
                end
            end
        end else if (wr_en) begin
            active[wr_sel][wr_addr] <= wr_data;
        end
    end
`endif

    // Combinational read of element (row, col) of the selected matrix.
    always_comb begin
        for (int unsigned p = 0; p < PORTS; p++) begin
            rd_data[p] = active[rd_sel[p]][{rd_row[p], rd_col[p]}];
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Systolic array source: streams diagonally skewed A rows (west lanes) and
// B columns (north lanes) out of a local operand bank after a clear pulse.
// Optional feature macro: FEEDER_PINGPONG_EN (double-buffered bank, writes
// accepted while busy).
module systolic_feeder #(
    parameter int N            = sys_array_pkg::N,
    parameter int DATA_W       = sys_array_pkg::DATA_W,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [3:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_err,
    input  logic              start,
    output logic              busy,
    output logic              arr_clr,
    output logic [DATA_W-1:0] inp_west0,
    output logic [DATA_W-1:0] inp_west1,
    output logic [DATA_W-1:0] inp_west2,
    output logic [DATA_W-1:0] inp_west3,
    output logic [DATA_W-1:0] inp_north0,
    output logic [DATA_W-1:0] inp_north1,
    output logic [DATA_W-1:0] inp_north2,
    output logic [DATA_W-1:0] inp_north3,
    output logic              done
);
    import sys_array_pkg::*;

    localparam int LANES   = 2 * N;
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_t             state, state_n;
    logic [2:0]         step, step_n;
    logic [DRAIN_W-1:0] drain, drain_n;

    logic busy_d, clr_d, done_d, wr_err_d, wr_accept, bank_load;

    logic              rd_sel  [LANES];
    logic [1:0]        rd_row  [LANES];
    logic [1:0]        rd_col  [LANES];
    logic [DATA_W-1:0] rd_data [LANES];
    logic [3:0]        lane_k  [N];
    logic              lane_ok [N];
    logic [DATA_W-1:0] west_d  [N];
    logic [DATA_W-1:0] north_d [N];
    logic [DATA_W-1:0] west_q  [N];
    logic [DATA_W-1:0] north_q [N];

    systolic_feeder_bank #(
        .PORTS(LANES)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_accept),
        .wr_sel  (wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
`ifdef FEEDER_PINGPONG_EN
        .load    (bank_load),
`endif
        .rd_sel  (rd_sel),
        .rd_row  (rd_row),
        .rd_col  (rd_col),
        .rd_data (rd_data)
    );

    // State, stream step and drain counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            step  <= '0;
            drain <= '0;
        end else begin
            state <= state_n;
            step  <= step_n;
            drain <= drain_n;
        end
    end

    // Next-state sequencing: IDLE -> CLEAR -> STREAM(0..STEPS-1) -> DRAIN -> DONE.
    always_comb begin
        state_n = state;
        step_n  = step;
        drain_n = drain;
        case (state)
            IDLE:   if (start) state_n = CLEAR;
            CLEAR: begin
                state_n = STREAM;
                step_n  = '0;
            end
            STREAM: begin
                if (step == 3'(STEPS - 1)) begin
                    state_n = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
                    drain_n = '0;
                end else begin
                    step_n = step + 3'd1;
                end
            end
            DRAIN: begin
                if (drain == DRAIN_W'(DRAIN_CYCLES - 1)) state_n = DONE;
                else drain_n = drain + DRAIN_W'(1);
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output can be registered.
    always_comb begin
        busy_d    = (state_n != IDLE);
        clr_d     = (state_n == CLEAR);
        done_d    = (state_n == DONE);
        bank_load = (state == IDLE) && start;
`ifdef FEEDER_PINGPONG_EN
        wr_accept = wr_en;
        wr_err_d  = 1'b0;
`else
        wr_accept = wr_en && (state == IDLE);
        wr_err_d  = wr_en && (state != IDLE);
`endif
    end

    // Skew addressing: west lane i reads A[i][t-i], north lane j reads B[t-j][j].
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            lane_k[i]    = {1'b0, step_n} - 4'(i);
            lane_ok[i]   = (state_n == STREAM) && ({1'b0, step_n} >= 4'(i)) && (lane_k[i] < 4'(N));
            rd_sel[i]    = 1'b0;
            rd_row[i]    = 2'(i);
            rd_col[i]    = lane_k[i][1:0];
            rd_sel[N+i]  = 1'b1;
            rd_row[N+i]  = lane_k[i][1:0];
            rd_col[N+i]  = 2'(i);
        end
    end

    // Lane muxes: pass bank data when the skewed index is in range, else zero.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            west_d[i]  = lane_ok[i] ? rd_data[i]   : '0;
            north_d[i] = lane_ok[i] ? rd_data[N+i] : '0;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= 1'b0;
            arr_clr <= 1'b0;
            done    <= 1'b0;
            wr_err  <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                west_q[i]  <= '0;
                north_q[i] <= '0;
            end
        end else begin
            busy    <= busy_d;
            arr_clr <= clr_d;
            done    <= done_d;
            wr_err  <= wr_err_d;
            for (int unsigned i = 0; i < N; i++) begin
                west_q[i]  <= west_d[i];
                north_q[i] <= north_d[i];
            end
        end
    end

    assign inp_west0  = west_q[0];
    assign inp_west1  = west_q[1];
    assign inp_west2  = west_q[2];
    assign inp_west3  = west_q[3];
    assign inp_north0 = north_q[0];
    assign inp_north1 = north_q[1];
    assign inp_north2 = north_q[2];
    assign inp_north3 = north_q[3];

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: each accepted start pushes the full
// per-cycle expected output trace; a negedge monitor pops and compares.
module tb_systolic_feeder;

    localparam int DRAIN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        wr_sel = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        start = 1'b0;
    logic        wr_err, busy, arr_clr, done;
    logic [15:0] inp_west0, inp_west1, inp_west2, inp_west3;
    logic [15:0] inp_north0, inp_north1, inp_north2, inp_north3;
    logic [15:0] west [4];
    logic [15:0] north [4];

    assign west[0]  = inp_west0;
    assign west[1]  = inp_west1;
    assign west[2]  = inp_west2;
    assign west[3]  = inp_west3;
    assign north[0] = inp_north0;
    assign north[1] = inp_north1;
    assign north[2] = inp_north2;
    assign north[3] = inp_north3;

    systolic_feeder #(
        .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_err     (wr_err),
        .start      (start),
        .busy       (busy),
        .arr_clr    (arr_clr),
        .inp_west0  (inp_west0),
        .inp_west1  (inp_west1),
        .inp_west2  (inp_west2),
        .inp_west3  (inp_west3),
        .inp_north0 (inp_north0),
        .inp_north1 (inp_north1),
        .inp_north2 (inp_north2),
        .inp_north3 (inp_north3),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int              cyc;
        logic            clr;
        logic            bsy;
        logic            dn;
        logic [3:0][15:0] w;
        logic [3:0][15:0] n;
    } frame_t;

    frame_t      sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          busy_until = -100;
    int          err_cyc = -100;
    logic [15:0] a_act [16];
    logic [15:0] b_act [16];
    logic [15:0] a_sh  [16];
    logic [15:0] b_sh  [16];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Compare every cycle against the scoreboard; no entry for this cycle means idle.
    always @(negedge clk) begin
        frame_t e;
        e = '0;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            check("sb_order", 16'(sb[0].cyc), 16'(cyc));
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) e = sb.pop_front();
        check("busy", 16'(busy), 16'(e.bsy));
        check("arr_clr", 16'(arr_clr), 16'(e.clr));
        check("done", 16'(done), 16'(e.dn));
        check("wr_err", 16'(wr_err), 16'(cyc == err_cyc));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("west%0d", i), west[i], e.w[i]);
            check($sformatf("north%0d", i), north[i], e.n[i]);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        start = 1'b0;
    endtask

    // Drive a write sampled at the next edge and update the reference bank.
    task automatic do_write(input logic sel, input int addr, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = addr[3:0];
        wr_data = d;
`ifdef FEEDER_PINGPONG_EN
        if (sel) b_sh[addr] = d;
        else     a_sh[addr] = d;
`else
        if (busy_until < cyc) begin
            if (sel) b_act[addr] = d;
            else     a_act[addr] = d;
        end else begin
            err_cyc = cyc + 1;
        end
`endif
    endtask

    // Drive start; if the feeder is idle, push the complete expected trace.
    task automatic do_start();
        int     base;
        frame_t f;
        start = 1'b1;
        if (busy_until < cyc) begin
`ifdef FEEDER_PINGPONG_EN
            a_act = a_sh;
            b_act = b_sh;
`endif
            base = cyc + 1;
            f = '0; f.cyc = base; f.bsy = 1'b1; f.clr = 1'b1;
            sb.push_back(f);
            for (int t = 0; t < 7; t++) begin
                f = '0; f.cyc = base + 1 + t; f.bsy = 1'b1;
                for (int l = 0; l < 4; l++) begin
                    if (t - l >= 0 && t - l < 4) begin
                        f.w[l] = a_act[l * 4 + (t - l)];
                        f.n[l] = b_act[(t - l) * 4 + l];
                    end
                end
                sb.push_back(f);
            end
            for (int d = 0; d < DRAIN; d++) begin
                f = '0; f.cyc = base + 8 + d; f.bsy = 1'b1;
                sb.push_back(f);
            end
            f = '0; f.cyc = base + 8 + DRAIN; f.bsy = 1'b1; f.dn = 1'b1;
            sb.push_back(f);
            busy_until = base + 8 + DRAIN;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_done", 16'(done), 16'h0);
        check("rst_west0", inp_west0, 16'h0);
        check("rst_north0", inp_north0, 16'h0);
        sb.delete();
        busy_until = -100;
        err_cyc = -100;
        for (int e = 0; e < 16; e++) begin
            a_act[e] = '0; b_act[e] = '0; a_sh[e] = '0; b_sh[e] = '0;
        end
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        for (int e = 0; e < 16; e++) begin
            a_act[e] = '0; b_act[e] = '0; a_sh[e] = '0; b_sh[e] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Run 1: A all 1.0, B[k][j] = (k+1)<<8
        for (int e = 0; e < 16; e++) begin
            next_cycle();
            do_write(1'b0, e, 16'h0100);
            next_cycle();
            do_write(1'b1, e, 16'((e / 4 + 1) << 8));
        end
        next_cycle();
        do_start();
        repeat (16) next_cycle();

        // Run 2: distinct A, last write coincides with start; re-start at t=2 ignored; write at t=1
        for (int e = 0; e < 16; e++) begin
            next_cycle();
            do_write(1'b0, e, 16'(16'h0100 * (e + 1)));
            if (e == 15) do_start();
        end
        repeat (3) next_cycle();
        do_write(1'b0, 0, 16'hFFFF);
        next_cycle();
        do_start();
        repeat (16) next_cycle();

        // Run 3: shows whether the mid-run write reached the streamed bank
        do_start();
        repeat (16) next_cycle();

        // Reset during t=4, then a run out of the cleared bank
        do_start();
        repeat (6) next_cycle();
        do_reset();
        repeat (3) next_cycle();
        do_start();
        repeat (16) next_cycle();

        // Back-to-back runs on random data
        for (int e = 0; e < 16; e++) begin
            next_cycle();
            do_write(1'b0, e, 16'($urandom));
            next_cycle();
            do_write(1'b1, e, 16'($urandom));
        end
        next_cycle();
        do_start();
        while (cyc < busy_until + 1) next_cycle();
        do_start();
        repeat (18) next_cycle();

        check("sb_empty", 16'(sb.size()), 16'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
